// File: rtl/fft_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_ctrl                                                        |
// | Purpose  : Sequencer for an in-place radix-2 DIF FFT. Issues per-butterfly |
// |            RAM read addresses, twiddle index, butterfly enable and the     |
// |            delayed write-back strobe/addresses, stage by stage, with a     |
// |            pipeline drain between stages.                                  |
// | Ports    : clk, rst_n        - clock, async active-low reset               |
// |            start/busy/done   - transform handshake                         |
// |            stage             - current stage index                         |
// |            rd_en, rd_addr_a/b, tw_addr - read side, aligned                |
// |            bf_enable         - rd_en delayed RD_LAT                        |
// |            wr_en, wr_addr_a/b - read side delayed RD_LAT+BF_LAT            |
// |            out_valid, out_addr - bit-reversed unload (optional)            |
// | Options  : FFT_CTRL_UNLOAD_EN adds an UNLOAD phase that reads the result   |
// |            back in natural order (bit-reversed RAM addresses).             |
// | Limits   : LOG2N >= 2, RD_LAT >= 1, BF_LAT >= 0.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fft_ctrl #(
   parameter int LOG2N  = 4,
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             bf_enable,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
`ifdef FFT_CTRL_UNLOAD_EN
   ,
   output logic             out_valid,
   output logic [LOG2N-1:0] out_addr
`endif
);

   localparam int N      = 1 << LOG2N;
   localparam int KW     = LOG2N - 1;
   localparam int WB_LAT = RD_LAT + BF_LAT;
   localparam int CW     = $clog2(WB_LAT + 1);

   localparam logic [KW-1:0]    K_LAST     = KW'(N / 2 - 1);
   localparam logic [LOG2N-1:0] S_LAST     = LOG2N'(LOG2N - 1);
   localparam logic [CW-1:0]    DRAIN_LAST = CW'(WB_LAT - 1);
`ifdef FFT_CTRL_UNLOAD_EN
   localparam logic [LOG2N-1:0] I_LAST     = LOG2N'(N - 1);
   localparam logic [CW-1:0]    UWAIT_LAST = CW'(RD_LAT - 1);
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_DONE   = 3'd3
`ifdef FFT_CTRL_UNLOAD_EN
      ,
      ST_UNLOAD = 3'd4,
      ST_UWAIT  = 3'd5
`endif
   } state_t;

   // ---------------------------------------------------------------- state
   state_t           state_q, state_d;
   logic [LOG2N-1:0] s_q, s_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // ------------------------------------------------------ output registers
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             rd_en_q, rd_en_d;
   logic             run_rd_q, run_rd_d;     // read belongs to a butterfly
   logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
   logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
   logic [KW-1:0]    tw_addr_q, tw_addr_d;

   // -------------------------------------------------- write-back delay line
   logic [WB_LAT-1:0] run_pipe_q, run_pipe_d;
   logic [LOG2N-1:0]  wa_pipe_q [WB_LAT];
   logic [LOG2N-1:0]  wa_pipe_d [WB_LAT];
   logic [LOG2N-1:0]  wb_pipe_q [WB_LAT];
   logic [LOG2N-1:0]  wb_pipe_d [WB_LAT];

   // ------------------------------------------------- butterfly addressing
   logic [LOG2N-1:0] half_w;
   logic [LOG2N-1:0] mask_w;
   logic [LOG2N-1:0] kx_w;
   logic [LOG2N-1:0] bf_a_w;
   logic [LOG2N-1:0] bf_b_w;
   logic [KW-1:0]    bf_tw_w;

`ifdef FFT_CTRL_UNLOAD_EN
   logic [LOG2N-1:0] i_q, i_d;
   logic             unl_rd_q, unl_rd_d;
   logic [LOG2N-1:0] uaddr_q, uaddr_d;
   logic [RD_LAT-1:0] uv_pipe_q, uv_pipe_d;
   logic [LOG2N-1:0] ua_pipe_q [RD_LAT];
   logic [LOG2N-1:0] ua_pipe_d [RD_LAT];

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int b = 0; b < LOG2N; b++) begin
         r[b] = v[LOG2N-1-b];
      end
      return r;
   endfunction
`endif

   // ------------------------------------------------------ next-state logic
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
`ifdef FFT_CTRL_UNLOAD_EN
      i_d     = i_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               s_d     = '0;
               k_d     = '0;
            end
         end
         ST_RUN: begin
            if (k_q == K_LAST) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Hold off the next stage until every write of this one has
            // landed, so no read can overtake a pending write.
            if (cnt_q == DRAIN_LAST) begin
               if (s_q != S_LAST) begin
                  state_d = ST_RUN;
                  s_d     = s_q + 1'b1;
                  k_d     = '0;
               end else begin
`ifdef FFT_CTRL_UNLOAD_EN
                  state_d = ST_UNLOAD;
                  i_d     = '0;
`else
                  state_d = ST_DONE;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            s_d     = '0;
         end
`ifdef FFT_CTRL_UNLOAD_EN
         ST_UNLOAD: begin
            if (i_q == I_LAST) begin
               state_d = ST_UWAIT;
               cnt_d   = '0;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         ST_UWAIT: begin
            // Let the last unload read reach out_valid before done.
            if (cnt_q == UWAIT_LAST) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // DIF addressing for butterfly k of stage s. half = (N/2) >> s is a power
   // of two, so k/half and k%half are a mask split; grp*2*half is the upper
   // part of k shifted up by one, and operand b sits exactly half above a.
   always_comb begin
      half_w  = LOG2N'(N / 2) >> s_d;
      mask_w  = half_w - 1'b1;
      kx_w    = {1'b0, k_d};
      bf_a_w  = ((kx_w & ~mask_w) << 1) | (kx_w & mask_w);
      bf_b_w  = bf_a_w | half_w;
      bf_tw_w = (k_d & mask_w[KW-1:0]) << s_d;
   end

   // ---------------------------------------------------- registered outputs
   always_comb begin
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      rd_en_d     = 1'b0;
      run_rd_d    = 1'b0;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      tw_addr_d   = tw_addr_q;
`ifdef FFT_CTRL_UNLOAD_EN
      unl_rd_d    = 1'b0;
      uaddr_d     = uaddr_q;
`endif
      if (state_d == ST_RUN) begin
         rd_en_d     = 1'b1;
         run_rd_d    = 1'b1;
         rd_addr_a_d = bf_a_w;
         rd_addr_b_d = bf_b_w;
         tw_addr_d   = bf_tw_w;
      end
`ifdef FFT_CTRL_UNLOAD_EN
      if (state_d == ST_UNLOAD) begin
         rd_en_d     = 1'b1;
         unl_rd_d    = 1'b1;
         rd_addr_a_d = bitrev(i_d);
         uaddr_d     = i_d;
      end
`endif
   end

   // ------------------------------------------------------ shift chains
   always_comb begin
      run_pipe_d[0] = run_rd_q;
      wa_pipe_d[0]  = rd_addr_a_q;
      wb_pipe_d[0]  = rd_addr_b_q;
      for (int j = 1; j < WB_LAT; j++) begin
         run_pipe_d[j] = run_pipe_q[j-1];
         wa_pipe_d[j]  = wa_pipe_q[j-1];
         wb_pipe_d[j]  = wb_pipe_q[j-1];
      end
   end

`ifdef FFT_CTRL_UNLOAD_EN
   always_comb begin
      uv_pipe_d[0] = unl_rd_q;
      ua_pipe_d[0] = uaddr_q;
      for (int j = 1; j < RD_LAT; j++) begin
         uv_pipe_d[j] = uv_pipe_q[j-1];
         ua_pipe_d[j] = ua_pipe_q[j-1];
      end
   end
`endif

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         run_rd_q    <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         tw_addr_q   <= '0;
         run_pipe_q  <= '0;
         for (int j = 0; j < WB_LAT; j++) begin
            wa_pipe_q[j] <= '0;
            wb_pipe_q[j] <= '0;
         end
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         run_rd_q    <= run_rd_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         tw_addr_q   <= tw_addr_d;
         run_pipe_q  <= run_pipe_d;
         for (int j = 0; j < WB_LAT; j++) begin
            wa_pipe_q[j] <= wa_pipe_d[j];
            wb_pipe_q[j] <= wb_pipe_d[j];
         end
      end
   end

`ifdef FFT_CTRL_UNLOAD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q       <= '0;
         unl_rd_q  <= 1'b0;
         uaddr_q   <= '0;
         uv_pipe_q <= '0;
         for (int j = 0; j < RD_LAT; j++) begin
            ua_pipe_q[j] <= '0;
         end
      end else begin
         i_q       <= i_d;
         unl_rd_q  <= unl_rd_d;
         uaddr_q   <= uaddr_d;
         uv_pipe_q <= uv_pipe_d;
         for (int j = 0; j < RD_LAT; j++) begin
            ua_pipe_q[j] <= ua_pipe_d[j];
         end
      end
   end

   assign out_valid = uv_pipe_q[RD_LAT-1];
   assign out_addr  = ua_pipe_q[RD_LAT-1];
`endif

   // --------------------------------------------------------------- outputs
   assign busy      = busy_q;
   assign done      = done_q;
   assign stage     = s_q;
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_addr_a_q;
   assign rd_addr_b = rd_addr_b_q;
   assign tw_addr   = tw_addr_q;
   assign bf_enable = run_pipe_q[RD_LAT-1];
   assign wr_en     = run_pipe_q[WB_LAT-1];
   assign wr_addr_a = wa_pipe_q[WB_LAT-1];
   assign wr_addr_b = wb_pipe_q[WB_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_ctrl                                                     |
// | Purpose  : Self-checking bench for fft_ctrl. A cycle-count reference model |
// |            (t = cycles since start accepted) predicts every output from   |
// |            the transform's timing and DIF addressing arithmetic.          |
// | Options  : FFT_CTRL_UNLOAD_EN (must match the DUT build)                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fft_ctrl;

   localparam int LOG2N   = 4;
   localparam int RD_LAT  = 1;
   localparam int BF_LAT  = 1;
   localparam int N       = 1 << LOG2N;
   localparam int STG_LEN = N / 2 + RD_LAT + BF_LAT;
   localparam int RUN_END = LOG2N * STG_LEN;
`ifdef FFT_CTRL_UNLOAD_EN
   localparam int DONE_T  = RUN_END + N + RD_LAT + 1;
`else
   localparam int DONE_T  = RUN_END + 1;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             busy;
   logic             done;
   logic [LOG2N-1:0] stage;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             bf_enable;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;
`ifdef FFT_CTRL_UNLOAD_EN
   logic             out_valid;
   logic [LOG2N-1:0] out_addr;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int t        = 0;   // model: 0 = idle, else cycles since start accepted

   fft_ctrl #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .stage     (stage),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .tw_addr   (tw_addr),
      .bf_enable (bf_enable),
      .wr_en     (wr_en),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
`ifdef FFT_CTRL_UNLOAD_EN
      ,
      .out_valid (out_valid),
      .out_addr  (out_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, obs, exp, t, $time);
      end
   endtask

`ifdef FFT_CTRL_UNLOAD_EN
   function automatic int bitrev(input int v);
      int r = 0;
      for (int b = 0; b < LOG2N; b++) begin
         if (((v >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
      end
      return r;
   endfunction
`endif

   // What the read side does in model cycle tt: butterfly reads stage by
   // stage (N/2 reads then a drain), then optionally the unload reads.
   function automatic void rd_model(input int tt, output bit en, output bit is_run,
                                    output int a, output int b, output int tw);
      int s, k, half, grp, pos;
      en = 0; is_run = 0; a = 0; b = 0; tw = 0;
      if (tt >= 1 && tt <= RUN_END) begin
         s = (tt - 1) / STG_LEN;
         k = (tt - 1) % STG_LEN;
         if (k < N / 2) begin
            half   = N / (2 ** (s + 1));
            grp    = k / half;
            pos    = k % half;
            en     = 1;
            is_run = 1;
            a      = grp * 2 * half + pos;
            b      = a + half;
            tw     = pos * (2 ** s);
         end
      end
`ifdef FFT_CTRL_UNLOAD_EN
      else if (tt > RUN_END && tt <= RUN_END + N) begin
         en = 1;
         a  = bitrev(tt - RUN_END - 1);
      end
`endif
   endfunction

   task automatic compare_cycle();
      bit en, is_run;
      int a, b, tw;
      rd_model(t, en, is_run, a, b, tw);
      check("rd_en", rd_en, en);
      if (en) check("rd_addr_a", rd_addr_a, a);
      if (en && is_run) begin
         check("rd_addr_b", rd_addr_b, b);
         check("tw_addr", tw_addr, tw);
      end
      rd_model(t - RD_LAT, en, is_run, a, b, tw);
      check("bf_enable", bf_enable, en && is_run);
`ifdef FFT_CTRL_UNLOAD_EN
      check("out_valid", out_valid, en && !is_run);
      if (en && !is_run) check("out_addr", out_addr, t - RD_LAT - RUN_END - 1);
`endif
      rd_model(t - RD_LAT - BF_LAT, en, is_run, a, b, tw);
      check("wr_en", wr_en, en && is_run);
      if (en && is_run) begin
         check("wr_addr_a", wr_addr_a, a);
         check("wr_addr_b", wr_addr_b, b);
      end
      check("busy", busy, (t >= 1 && t <= DONE_T));
      check("done", done, (t == DONE_T));
      if (t >= 1 && t <= RUN_END) check("stage", stage, (t - 1) / STG_LEN);
   endtask

   task automatic check_zero();
      check("z_busy", busy, 0);
      check("z_done", done, 0);
      check("z_stage", stage, 0);
      check("z_rd_en", rd_en, 0);
      check("z_rd_addr_a", rd_addr_a, 0);
      check("z_rd_addr_b", rd_addr_b, 0);
      check("z_tw_addr", tw_addr, 0);
      check("z_bf_enable", bf_enable, 0);
      check("z_wr_en", wr_en, 0);
      check("z_wr_addr_a", wr_addr_a, 0);
      check("z_wr_addr_b", wr_addr_b, 0);
`ifdef FFT_CTRL_UNLOAD_EN
      check("z_out_valid", out_valid, 0);
      check("z_out_addr", out_addr, 0);
`endif
   endtask

   // One clock: drive start, advance the model at the edge, check at negedge.
   task automatic cycle(input logic st);
      start = st;
      @(posedge clk);
      if (!rst_n)             t = 0;
      else if (t == 0)        t = st ? 1 : 0;
      else if (t == DONE_T)   t = 0;
      else                    t = t + 1;
      @(negedge clk);
      compare_cycle();
   endtask

   // Called at a negedge: reset lands mid-cycle and must clear at once.
   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      #1;
      check_zero();
      for (int c = 0; c < hold; c++) cycle(1'($urandom_range(0, 1)));
      rst_n = 1'b1;
   endtask

   initial begin
      int wr_cnt, done_cnt, done_at;
      rst_n = 1'b1;
      start = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      // Reset held with start toggling, then released with start low.
      for (int c = 0; c < 4; c++) cycle(1'(c % 2));
      check_zero();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) cycle(1'b0);
      check_zero();

      // Single transform with explicit anchors and pulse counts.
      wr_cnt = 0; done_cnt = 0; done_at = 0;
      cycle(1'b1);
      for (int c = 1; c <= DONE_T + 2; c++) begin
         if (wr_en) wr_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = c;
         end
         if (c == 1)  begin check("tp_c1_a", rd_addr_a, 0);   check("tp_c1_b", rd_addr_b, 8);   check("tp_c1_tw", tw_addr, 0); end
         if (c == 4)  begin check("tp_c4_a", rd_addr_a, 3);   check("tp_c4_b", rd_addr_b, 11);  check("tp_c4_tw", tw_addr, 3); end
         if (c == 16) begin check("tp_c16_a", rd_addr_a, 9);  check("tp_c16_b", rd_addr_b, 13); check("tp_c16_tw", tw_addr, 2); end
         if (c == 38) begin check("tp_c38_a", rd_addr_a, 14); check("tp_c38_b", rd_addr_b, 15); check("tp_c38_tw", tw_addr, 0); end
         cycle(1'b0);
      end
      check("wr_pulses", wr_cnt, LOG2N * N / 2);
      check("done_pulses", done_cnt, 1);
      check("done_cycle", done_at, DONE_T);

      // Start held high: two back-to-back transforms, restart from IDLE.
      done_cnt = 0;
      for (int c = 1; c <= 2 * (DONE_T + 1); c++) begin
         cycle(1'b1);
         if (done) done_cnt++;
      end
      check("held_start_dones", done_cnt, 2);
      for (int c = 0; c < 3; c++) cycle(1'b0);

      // Randomized start pattern with occasional mid-run reset.
      for (int c = 0; c < 1500; c++) begin
         cycle(1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 399) == 0) do_reset(2);
      end
      for (int c = 0; c < DONE_T + 2; c++) cycle(1'b0);

      // Reset in cycle 15 of a run: aborts with no further activity.
      cycle(1'b1);
      for (int c = 2; c <= 15; c++) cycle(1'b0);
      check("pre_abort_busy", busy, 1);
      do_reset(2);
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         cycle(1'b0);
         if (done || rd_en || wr_en) done_cnt++;
      end
      check("post_abort_activity", done_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
